// File: rtl/ex_muldiv_pkg.sv
// Shared opcode, divider-state and constant definitions for the EX-stage multiply/divide unit.
package ex_muldiv_pkg;

    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FREE   = DivFree,
        ST_BYZERO = DivByZero,
        ST_ON     = DivOn,
        ST_END    = DivEnd
    } div_state_t;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/muldiv_div.sv
// 32-cycle restoring divider (signed/unsigned) with FREE/BYZERO/ON/END control FSM.
module muldiv_div
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
    input  logic        i_signed,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic        i_annul,
    input  logic        i_hold,
    output logic        o_ready,
    output logic [63:0] o_result
);

    div_state_t  r_state, w_state_next;
    logic [5:0]  r_cnt, w_cnt_next;
    logic [31:0] r_rem, w_rem_next;
    logic [31:0] r_quo, w_quo_next;
    logic [31:0] r_div, w_div_next;
    logic        r_neg_q, w_neg_q_next;
    logic        r_neg_r, w_neg_r_next;

    logic [31:0] w_a_mag, w_b_mag;
    logic [32:0] w_trial, w_diff;

    assign w_a_mag = (i_signed && i_op_a[31]) ? (~i_op_a + 32'd1) : i_op_a;
    assign w_b_mag = (i_signed && i_op_b[31]) ? (~i_op_b + 32'd1) : i_op_b;

    // Remainder < divisor is invariant, so the borrow bit alone decides restore vs. keep.
    assign w_trial = {r_rem, r_quo[31]};
    assign w_diff  = w_trial - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FREE;
            r_cnt   <= 6'd0;
            r_rem   <= ZeroWord;
            r_quo   <= ZeroWord;
            r_div   <= ZeroWord;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_rem   <= w_rem_next;
            r_quo   <= w_quo_next;
            r_div   <= w_div_next;
            r_neg_q <= w_neg_q_next;
            r_neg_r <= w_neg_r_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_rem_next   = r_rem;
        w_quo_next   = r_quo;
        w_div_next   = r_div;
        w_neg_q_next = r_neg_q;
        w_neg_r_next = r_neg_r;
        if (i_annul) begin
            w_state_next = ST_FREE;
            w_cnt_next   = 6'd0;
        end else if (!i_hold) begin
            case (r_state)
                ST_FREE: begin
                    if (i_start) begin
                        w_neg_q_next = i_signed && (i_op_a[31] ^ i_op_b[31]);
                        w_neg_r_next = i_signed && i_op_a[31];
                        w_rem_next   = ZeroWord;
                        w_quo_next   = w_a_mag;
                        w_div_next   = w_b_mag;
                        w_cnt_next   = 6'd0;
                        w_state_next = (i_op_b == ZeroWord) ? ST_BYZERO : ST_ON;
                    end
                end
                ST_BYZERO: begin
                    w_rem_next   = ZeroWord;
                    w_quo_next   = ZeroWord;
                    w_state_next = ST_END;
                end
                ST_ON: begin
                    w_rem_next = w_diff[32] ? w_trial[31:0] : w_diff[31:0];
                    w_quo_next = {r_quo[30:0], ~w_diff[32]};
                    if (r_cnt == 6'd31) begin
                        w_cnt_next   = 6'd0;
                        w_state_next = ST_END;
                    end else begin
                        w_cnt_next = r_cnt + 6'd1;
                    end
                end
                ST_END: begin
                    w_state_next = ST_FREE;
                end
                default: w_state_next = ST_FREE;
            endcase
        end
    end

    assign o_ready  = (r_state == ST_END);
    assign o_result = {(r_neg_r ? (~r_rem + 32'd1) : r_rem),
                       (r_neg_q ? (~r_quo + 32'd1) : r_quo)};

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage HI/LO unit: single-cycle MULT/MULTU, two-cycle MADD/MSUB family (OPENMIPS_MADD_EN),
// and iterative DIV/DIVU via muldiv_div.
module ex_muldiv
    import ex_muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        hold_i,
    input  logic        annul_i,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    logic        w_div_op;
    logic        w_div_ready;
    logic [63:0] w_div_result;
    logic [63:0] w_a_s, w_b_s, w_a_u, w_b_u;
    logic [63:0] w_prod_s, w_prod_u;

    assign w_a_s    = {{32{reg1_i[31]}}, reg1_i};
    assign w_b_s    = {{32{reg2_i[31]}}, reg2_i};
    assign w_a_u    = {32'd0, reg1_i};
    assign w_b_u    = {32'd0, reg2_i};
    assign w_prod_s = w_a_s * w_b_s;
    assign w_prod_u = w_a_u * w_b_u;
    assign w_div_op = is_div_op(aluop_i);

    muldiv_div u_div (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_div_op),
        .i_signed (aluop_i == EXE_DIV_OP),
        .i_op_a   (reg1_i),
        .i_op_b   (reg2_i),
        .i_annul  (annul_i),
        .i_hold   (hold_i),
        .o_ready  (w_div_ready),
        .o_result (w_div_result)
    );

`ifdef OPENMIPS_MADD_EN
    logic        r_madd_phase;
    logic [63:0] r_prod_reg;
    logic        w_madd_op, w_madd_signed, w_madd_sub;
    logic [63:0] w_madd_result;

    assign w_madd_op     = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MADDU_OP) ||
                           (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    assign w_madd_signed = (aluop_i == EXE_MADD_OP) || (aluop_i == EXE_MSUB_OP);
    assign w_madd_sub    = (aluop_i == EXE_MSUB_OP) || (aluop_i == EXE_MSUBU_OP);
    assign w_madd_result = w_madd_sub ? ({hi_i, lo_i} - r_prod_reg) : ({hi_i, lo_i} + r_prod_reg);

    // A flush drops the phase too, so a following MADD never reuses a stale product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_madd_phase <= 1'b0;
            r_prod_reg   <= 64'd0;
        end else if (annul_i) begin
            r_madd_phase <= 1'b0;
        end else if (!hold_i) begin
            if (w_madd_op && !r_madd_phase) begin
                r_madd_phase <= 1'b1;
                r_prod_reg   <= w_madd_signed ? w_prod_s : w_prod_u;
            end else begin
                r_madd_phase <= 1'b0;
            end
        end
    end
`else
    logic w_unused_hilo;
    assign w_unused_hilo = ^{hi_i, lo_i};
`endif

    always_comb begin
        whilo_o    = 1'b0;
        hi_o       = ZeroWord;
        lo_o       = ZeroWord;
        stallreq_o = 1'b0;
        case (aluop_i)
            EXE_MULT_OP: begin
                whilo_o      = 1'b1;
                {hi_o, lo_o} = w_prod_s;
            end
            EXE_MULTU_OP: begin
                whilo_o      = 1'b1;
                {hi_o, lo_o} = w_prod_u;
            end
            EXE_DIV_OP, EXE_DIVU_OP: begin
                stallreq_o = !w_div_ready;
                if (w_div_ready && !annul_i) begin
                    whilo_o      = 1'b1;
                    {hi_o, lo_o} = w_div_result;
                end
            end
`ifdef OPENMIPS_MADD_EN
            EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP: begin
                if (!r_madd_phase) begin
                    stallreq_o = 1'b1;
                end else begin
                    whilo_o      = 1'b1;
                    {hi_o, lo_o} = w_madd_result;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL provide clk  input  1  system clock, rising-edge active.
REQ-002 SHALL provide rst  input  1  synchronous, active-high reset.
REQ-003 SHALL provide aluop_i  input  8  operation code registered by the ID/EX pipeline register.
REQ-004 SHALL provide reg1_i  input  32  operand A (dividend / multiplicand).
REQ-005 SHALL provide reg2_i  input  32  operand B (divisor / multiplier).
REQ-006 SHALL provide hi_i, lo_i  input  32 each  current forwarded HI/LO values.
REQ-007 SHALL provide hold_i  input  1  downstream stall; when 1, progress is frozen.
REQ-008 SHALL provide annul_i  input  1  aborts any divide in progress.
REQ-009 SHALL provide whilo_o  output  1  HI/LO write enable.
REQ-010 SHALL provide hi_o, lo_o  output  32 each  HI/LO write data.
REQ-011 SHALL provide stallreq_o  output  1  request to stall IF/ID/EX.

Function
REQ-012 SHALL, for MULT/MULTU, produce the 64-bit signed/unsigned product as {hi_o,lo_o} with whilo_o=1 in the same cycle (0 latency) and stallreq_o=0.
REQ-013 SHALL, for MADD/MADDU/MSUB/MSUBU, register the product in cycle 1 with stallreq_o=1 and whilo_o=0; in cycle 2, drive {hi_i,lo_i} ± product with whilo_o=1 and stallreq_o=0.
REQ-014 SHALL wrap MADD/MSUB arithmetic modulo 2^64 with no overflow flag.
REQ-015 SHALL implement DIV/DIVU with FSM states FREE, BYZERO, ON, END.
REQ-016 SHALL transition FREE->BYZERO when the op is a divide and reg2_i==0, FREE->ON when the op is a divide otherwise; stallreq_o=1 in FREE on a divide op.
REQ-017 SHALL perform one restoring iteration per cycle in ON for exactly 32 cycles, driven by a 6-bit counter, then go to END.
REQ-018 SHALL transition BYZERO->END after 1 cycle with result {HI,LO}=0.
REQ-019 SHALL, in END, drive hi_o=remainder, lo_o=quotient, whilo_o=1 and stallreq_o=0; stay in END while hold_i=1 and return to FREE when hold_i=0.
REQ-020 SHALL, for signed DIV, divide magnitudes and negate the quotient when the operand signs differ; the remainder SHALL take the dividend's sign.
REQ-021 SHALL assert whilo_o for a non-zero divide 33 cycles after issue (stallreq_o high for cycles 0..32).
REQ-022 SHALL force the next state to FREE on annul_i=1 in any state, with whilo_o=0 that cycle.
REQ-023 SHALL freeze the FSM, counter and MADD phase while hold_i=1, except as stated in REQ-019.
REQ-024 SHALL drive whilo_o=0, hi_o=lo_o=0 and stallreq_o=0 for any other aluop_i.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set the FSM to FREE, the counter to 0, the MADD phase to 0 and the product register to 0, aborting any in-flight operation.
REQ-026 SHALL hold whilo_o=0 and stallreq_o=0 on the cycle after reset.

Configuration
REQ-027 SHALL compile MADD/MADDU/MSUB/MSUBU support only when OPENMIPS_MADD_EN is defined.
REQ-028 SHALL, when OPENMIPS_MADD_EN is not defined, treat those ops per REQ-024 and omit the product register.

Structure
REQ-029 SHALL take the aluop codes, the FSM state encodings (DivFree, DivByZero, DivOn, DivEnd) and ZeroWord from the shared define include.
REQ-030 SHALL place the divider FSM and datapath in sub-module muldiv_div; multiply and MADD logic SHALL reside in ex_muldiv.

Verification
REQ-031 SHALL cover: MULT 0xFFFFFFFF × 0x00000002 -> same cycle whilo_o=1, hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFE.
REQ-032 SHALL cover: MADDU 3 × 4 with hi_i=0, lo_i=0xFFFFFFFF -> stallreq_o=1 for 1 cycle, then hi_o=1, lo_o=0x0000000B.
REQ-033 SHALL cover: DIV -7 / 2 -> stallreq_o=1 for 33 cycles, then lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF.
REQ-034 SHALL cover: DIVU 5 / 0 -> END on cycle 2, hi_o=lo_o=0, whilo_o=1.
REQ-035 SHALL cover: DIVU 100 / 7 with annul_i=1 at cycle 10 -> FREE next cycle, no whilo_o pulse.
REQ-036 SHALL cover: DIVU 100 / 7 with hold_i=1 for 3 cycles in END -> whilo_o stays 1, hi_o=2, lo_o=14, then FREE.
